// File: rtl/sub16_pipe.sv
// 16-bit subtractor D = A - B as a 4-stage pipeline of 4-bit borrow-lookahead slices,
// least-significant nibble first, with borrow, zero and signed-overflow flags.
module sub16_pipe (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        En,
   input  logic        InValid,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [15:0] D,
   output logic        Bout,
   output logic        Zero,
   output logic        Ovf,
   output logic        OutValid
);

   localparam int unsigned W  = 16;
   localparam int unsigned SW = 4;

   // One 4-bit borrow-lookahead slice: returns {borrow_out, diff[3:0]}
   function automatic logic [SW:0] bl_slice(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b,
                                            input logic          bin);
      logic [SW-1:0] g;
      logic [SW-1:0] p;
      logic [SW:0]   br;
      g     = ~a & b;
      p     = ~(a ^ b);
      br[0] = bin;
      br[1] = g[0] | (p[0] & bin);
      br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
      br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
      br[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & bin);
      return {br[SW], a ^ b ^ br[SW-1:0]};
   endfunction

   // Stage registers: valid, low difference bits, slice borrow, unconsumed operand bits
   logic          s0_v_q, s1_v_q, s2_v_q;
   logic [3:0]    s0_d_q;
   logic [7:0]    s1_d_q;
   logic [11:0]   s2_d_q;
   logic          s0_br_q, s1_br_q, s2_br_q;
   logic [11:0]   s0_a_q, s0_b_q;
   logic [7:0]    s1_a_q, s1_b_q;
   logic [3:0]    s2_a_q, s2_b_q;

   logic [W-1:0]  d_q, d_d;
   logic          bout_q, bout_d;
   logic          zero_q, zero_d;
   logic          ovf_q, ovf_d;
   logic          ovalid_q;

   logic [SW:0]   sl0_c, sl1_c, sl2_c, sl3_c;

   always_comb begin
      sl0_c  = bl_slice(A[3:0], B[3:0], 1'b0);
      sl1_c  = bl_slice(s0_a_q[3:0], s0_b_q[3:0], s0_br_q);
      sl2_c  = bl_slice(s1_a_q[3:0], s1_b_q[3:0], s1_br_q);
      sl3_c  = bl_slice(s2_a_q, s2_b_q, s2_br_q);
      d_d    = {sl3_c[SW-1:0], s2_d_q};
      bout_d = sl3_c[SW];
      zero_d = (d_d == W'(0));
      // s2_a_q[3]/s2_b_q[3] are the original A[15]/B[15]
      ovf_d  = (s2_a_q[3] ^ s2_b_q[3]) & (d_d[W-1] ^ s2_a_q[3]);
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         s0_v_q   <= 1'b0;
         s1_v_q   <= 1'b0;
         s2_v_q   <= 1'b0;
         s0_d_q   <= '0;
         s1_d_q   <= '0;
         s2_d_q   <= '0;
         s0_br_q  <= 1'b0;
         s1_br_q  <= 1'b0;
         s2_br_q  <= 1'b0;
         s0_a_q   <= '0;
         s0_b_q   <= '0;
         s1_a_q   <= '0;
         s1_b_q   <= '0;
         s2_a_q   <= '0;
         s2_b_q   <= '0;
         d_q      <= '0;
         bout_q   <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         ovalid_q <= 1'b0;
      end else if (En) begin
         s0_v_q   <= InValid;
         s0_d_q   <= sl0_c[SW-1:0];
         s0_br_q  <= sl0_c[SW];
         s0_a_q   <= A[15:4];
         s0_b_q   <= B[15:4];

         s1_v_q   <= s0_v_q;
         s1_d_q   <= {sl1_c[SW-1:0], s0_d_q};
         s1_br_q  <= sl1_c[SW];
         s1_a_q   <= s0_a_q[11:4];
         s1_b_q   <= s0_b_q[11:4];

         s2_v_q   <= s1_v_q;
         s2_d_q   <= {sl2_c[SW-1:0], s1_d_q};
         s2_br_q  <= sl2_c[SW];
         s2_a_q   <= s1_a_q[7:4];
         s2_b_q   <= s1_b_q[7:4];

         ovalid_q <= s2_v_q;
         if (s2_v_q) begin
            d_q    <= d_d;
            bout_q <= bout_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
         end
      end
   end

   assign D        = d_q;
   assign Bout     = bout_q;
   assign Zero     = zero_q;
   assign Ovf      = ovf_q;
   assign OutValid = ovalid_q;

endmodule

// File: tb/tb_sub16_pipe.sv
// Self-checking bench for sub16_pipe: scoreboard of expected results keyed by the
// enabled edge on which each one must appear.
module tb_sub16_pipe;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        En;
   logic        InValid;
   logic [15:0] A;
   logic [15:0] B;
   logic [15:0] D;
   logic        Bout;
   logic        Zero;
   logic        Ovf;
   logic        OutValid;

   sub16_pipe dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .En       (En),
      .InValid  (InValid),
      .A        (A),
      .B        (B),
      .D        (D),
      .Bout     (Bout),
      .Zero     (Zero),
      .Ovf      (Ovf),
      .OutValid (OutValid)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [15:0] d;
      logic        bout;
      logic        zero;
      logic        ovf;
      int          due;
   } exp_t;

   exp_t sb[$];
   int   n_cmp    = 0;
   int   n_fail   = 0;
   int   edge_cnt = 0;
   int   n_pulse  = 0;

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input int due);
      exp_t        e;
      logic [16:0] t;
      t      = {1'b0, a} - {1'b0, b};
      e.d    = t[15:0];
      e.bout = t[16];
      e.zero = (t[15:0] == 16'h0000);
      e.ovf  = (a[15] ^ b[15]) & (t[15] ^ a[15]);
      e.due  = due;
      return e;
   endfunction

   // Drive one cycle from a falling edge, scoreboard the result on the next falling edge
   task automatic step(input logic en, input logic iv, input logic [15:0] a, input logic [15:0] b);
      logic [19:0] prev;
      exp_t        e;
      prev = {D, Bout, Zero, Ovf};
      if (en && iv && Rst) sb.push_back(model(a, b, edge_cnt + 4));
      En = en; InValid = iv; A = a; B = b;
      @(posedge Clk);
      if (en && Rst) edge_cnt++;
      @(negedge Clk);
      if (!Rst) begin
         // reset in progress: scoreboarding is done by the caller
      end else if (!en) begin
         n_cmp++;
         if ({D, Bout, Zero, Ovf} !== prev) begin
            n_fail++;
            $display("FAIL stall_hold: got %h required %h", {D, Bout, Zero, Ovf}, prev);
         end
      end else if (OutValid) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_outvalid: got OutValid=1 D=%h at edge %0d, none required", D, edge_cnt);
         end else begin
            e = sb.pop_front();
            n_pulse++;
            if ({D, Bout, Zero, Ovf} !== {e.d, e.bout, e.zero, e.ovf} || edge_cnt != e.due) begin
               n_fail++;
               $display("FAIL result: got D=%h Bout=%b Zero=%b Ovf=%b edge=%0d required D=%h Bout=%b Zero=%b Ovf=%b edge=%0d",
                        D, Bout, Zero, Ovf, edge_cnt, e.d, e.bout, e.zero, e.ovf, e.due);
            end
         end
      end else if (sb.size() > 0 && sb[0].due <= edge_cnt) begin
         n_cmp++;
         n_fail++;
         $display("FAIL missing_result: got OutValid=0 at edge %0d required D=%h", edge_cnt, sb[0].d);
         void'(sb.pop_front());
      end
   endtask

   task automatic test_reset();
      Rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         En = 1'($urandom); InValid = 1'($urandom);
         A = 16'($urandom); B = 16'($urandom);
         @(negedge Clk);
         n_cmp++;
         if ({D, Bout, Zero, Ovf, OutValid} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_hold: got D=%h Bout=%b Zero=%b Ovf=%b OutValid=%b required all 0",
                     D, Bout, Zero, Ovf, OutValid);
         end
      end
      Rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 16'hFFFF, 16'h0001);
         n_cmp++;
         if (OutValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got OutValid=%b required 0", OutValid);
         end
      end
   endtask

   // Single op with spec-given expected values, checked 4 cycles after issue
   task automatic test_single(input string name, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] ed, input logic eb, input logic ez, input logic eo);
      step(1'b1, 1'b1, a, b);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h0, 16'h0);
      n_cmp++;
      if ({OutValid, D, Bout, Zero, Ovf} !== {1'b1, ed, eb, ez, eo}) begin
         n_fail++;
         $display("FAIL %s: got OutValid=%b D=%h Bout=%b Zero=%b Ovf=%b required 1 %h %b %b %b",
                  name, OutValid, D, Bout, Zero, Ovf, ed, eb, ez, eo);
      end
      step(1'b1, 1'b0, 16'h0, 16'h0);
      n_cmp++;
      if (OutValid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_pulse_width: got OutValid=%b required 0", name, OutValid);
      end
   endtask

   task automatic test_basic();
      test_single("basic", 16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_borrow_zero();
      test_single("full_borrow", 16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      test_single("zero",        16'h5555, 16'h5555, 16'h0000, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_overflow();
      test_single("ovf_neg", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1);
      test_single("ovf_pos", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back_stall();
      int i;
      int p0;
      logic en;
      i  = 1;
      p0 = n_pulse;
      for (int t = 0; t < 14; t++) begin
         en = !(t == 3 || t == 4);
         if (en && i <= 6) begin
            step(1'b1, 1'b1, 16'(i * 16'h1111), 16'h0101);
            i++;
         end else begin
            step(en, 1'b0, 16'hDEAD, 16'hBEEF);
         end
      end
      n_cmp++;
      if (n_pulse - p0 != 6 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL stream_count: got %0d pulses (%0d pending) required 6 (0 pending)",
                  n_pulse - p0, sb.size());
      end
   endtask

   task automatic test_reset_mid();
      int p0;
      step(1'b1, 1'b1, 16'hA000, 16'h0001);
      step(1'b1, 1'b1, 16'hB000, 16'h0002);
      step(1'b1, 1'b1, 16'hC000, 16'h0003);
      #2 Rst = 1'b0;
      #1;
      n_cmp++;
      if ({D, Bout, Zero, Ovf, OutValid} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_async: got D=%h Bout=%b Zero=%b Ovf=%b OutValid=%b required all 0",
                  D, Bout, Zero, Ovf, OutValid);
      end
      sb.delete();
      @(negedge Clk);
      Rst = 1'b1;
      p0  = n_pulse;
      for (int t = 0; t < 5; t++) step(1'b1, 1'b0, 16'h0, 16'h0);
      step(1'b1, 1'b1, 16'h0100, 16'h0200);
      for (int t = 0; t < 5; t++) step(1'b1, 1'b0, 16'h0, 16'h0);
      n_cmp++;
      if (n_pulse - p0 != 1 || sb.size() != 0) begin
         n_fail++;
         $display("FAIL reset_mid_count: got %0d pulses (%0d pending) required 1 (0 pending)",
                  n_pulse - p0, sb.size());
      end
   endtask

   initial begin
      Rst = 1'b0; En = 1'b0; InValid = 1'b0; A = '0; B = '0;
      test_reset();
      test_basic();
      test_borrow_zero();
      test_overflow();
      test_back_to_back_stall();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within bound");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sub16_pipe.md
# sub16_pipe

16-bit unsigned/two's-complement subtractor computing D = A - B, built as a 4-stage pipeline of 4-bit borrow-lookahead slices, one nibble per stage, least-significant nibble first. It is the subtract-direction counterpart of the group's 16-bit carry-lookahead adder and sits beside it in the datapath. It accepts one operand pair per clock and returns the difference with borrow, zero and signed-overflow flags after a fixed latency. A global enable freezes the whole pipeline.

## Interface
- No parameters. Width is fixed at 16 bits: 4 slices of 4 bits.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- En  in  1  pipeline advance enable; when 0, every pipeline register holds.
- InValid  in  1  A/B are a valid operation this cycle.
- A  in  16  minuend.
- B  in  16  subtrahend.
- D  out  16  registered difference A - B mod 2^16.
- Bout  out  1  borrow out of bit 15; 1 when A < B unsigned.
- Zero  out  1  1 when D == 16'h0000.
- Ovf  out  1  signed overflow: (A[15]^B[15]) & (D[15]^A[15]).
- OutValid  out  1  D/Bout/Zero/Ovf carry a new result this cycle.

## Operation
- Slice k (k = 0..3) handles bits 4k+3..4k.
  - Per bit: generate g = ~a & b; propagate p = ~(a ^ b).
  - Borrow lookahead: b(i+1) = g(i) | p(i) & b(i).
  - Difference: d = a ^ b ^ borrow.
  - Stage 0 borrow-in is 0.
- Stage k register contents:
  - valid bit;
  - difference bits produced so far, D[4k+3:0];
  - borrow out of the slice;
  - the unconsumed A and B bits above the slice;
  - A[15] and B[15], carried through for the overflow flag.
- Stage 3 (output stage) computes the final flags from its slice result: D, Bout = borrow out of bit 15, Zero, and Ovf.
- Outputs update only on an enabled edge where the stage-2 valid bit is 1. Otherwise D, Bout, Zero and Ovf hold their last values.
- OutValid is the registered stage-3 valid bit.
- Operations with InValid = 0 still enter the pipeline as bubbles (valid = 0). Their data is don't-care and never reaches the outputs.
- No backpressure. Throughput is one operation per enabled cycle, and results emerge in issue order.
- En = 0:
  - all stage registers, valid bits and outputs hold;
  - A, B and InValid are ignored that cycle;
  - OutValid keeps its value, so a result already presented stays presented.
- Rst = 0, asynchronous and at any time including mid-stream:
  - all valid bits clear; in-flight operations are discarded;
  - D = 0, Bout = 0, Zero = 0, Ovf = 0, OutValid = 0;
  - after release, the first result appears only from an operation issued after release.
- Signed and unsigned interpretation share the same D. Bout is the unsigned-compare flag; Ovf is the signed flag.

## Timing
- Latency is 4 enabled rising edges.
  - An op sampled on enabled edge N (InValid = 1) produces OutValid = 1 after enabled edge N+3.
  - With En held at 1, the result is visible 4 cycles after InValid is presented.
- Each enabled edge with En = 0 between issue and output adds exactly one cycle of latency.
- Back-to-back ops on consecutive enabled edges give results on consecutive cycles.
- Combinational depth per stage is one 4-bit lookahead slice. There is no full-width ripple path.
- Reset values: all outputs 0, all valid bits 0.
- Reset assertion takes effect immediately, independent of Clk.

## Test plan
- Reset: hold Rst = 0 with random A/B/InValid/En.
  - Required: D = 0000, Bout = 0, Zero = 0, Ovf = 0, OutValid = 0 throughout.
  - After release with no InValid: OutValid stays 0.
- Basic: A = 1234h, B = 0034h, InValid on one cycle, En = 1.
  - Required: 4 cycles later OutValid = 1 for one cycle, D = 1200h, Bout = 0, Zero = 0, Ovf = 0.
- Full borrow ripple and zero:
  - A = 0000h, B = 0001h → D = FFFFh, Bout = 1, Ovf = 0.
  - A = 5555h, B = 5555h → D = 0000h, Zero = 1, Bout = 0.
- Signed overflow:
  - A = 8000h, B = 0001h → D = 7FFFh, Ovf = 1, Bout = 0.
  - A = 7FFFh, B = FFFFh → D = 8000h, Ovf = 1, Bout = 1.
- Streaming with stall: issue 6 back-to-back ops (A = i·1111h, B = 0101h, i = 1..6), drop En for 2 cycles after the third issue.
  - Required: 6 results in order, each D = i·1111h - 0101h, shifted 2 cycles after the stall.
  - No duplicate or lost OutValid pulses; outputs hold during the stall.
- Reset mid-stream: 3 ops in flight, pulse Rst = 0 asynchronously between edges.
  - Required: outputs go to 0 immediately and OutValid = 0.
  - None of the 3 results ever appear; a new op issued after release completes with the normal 4-cycle latency.
